// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the parametrised register bank.
// Bank state, address-width helper and the reset/zero data value.
package reg_bank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int MAX_XLEN = 64;

  // Value written by the clear sweep and returned by masked reads; sliced to XLEN by users.
  localparam logic [MAX_XLEN-1:0] RESET_DATA = '0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_bank_param_if.sv
// Decode/writeback-facing bus of the register bank: one write port plus NRP read ports.
// Handshake: there is no flow control; a write is taken on the rising edge when wr_en_i is high and ready_o is high, and reads are combinational.
interface reg_bank_param_if
  import reg_bank_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  localparam int AW = clog2(NREGS);

  logic                wr_en_i;
  logic [AW-1:0]       rd_addr_i;
  logic [XLEN-1:0]     data_i;
  logic [NRP*AW-1:0]   rs_addr_i;
  logic [NRP*XLEN-1:0] rs_data_o;
  logic                ready_o;

  modport master (
    output wr_en_i,
    output rd_addr_i,
    output data_i,
    output rs_addr_i,
    input  rs_data_o,
    input  ready_o
  );

  modport slave (
    input  wr_en_i,
    input  rd_addr_i,
    input  data_i,
    input  rs_addr_i,
    output rs_data_o,
    output ready_o
  );

endinterface

// File: rtl/reg_bank_read_port.sv
// One asynchronous read port: read mux plus zero-register, out-of-range and clear masking.
// With REG_BANK_BYPASS_EN defined, a qualifying same-cycle write is forwarded to the output.
module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  state_t          state_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] regs_i [NREGS],
`ifdef REG_BANK_BYPASS_EN
  input  logic            wr_qual_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
`endif
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sel;
  logic            masked;

  always_comb begin
    sel = RESET_DATA[XLEN-1:0];
    // Loop-compare mux keeps non-power-of-two depths free of out-of-range indexing.
    for (int i = 0; i < NREGS; i++) begin
      if (addr_i == AW'(i)) begin
        sel = regs_i[i];
      end
    end
    masked = (state_i == ST_CLEAR) ||
             ((ZERO_REG != 0) && (addr_i == '0)) ||
             (32'(addr_i) >= NREGS);
    data_o = masked ? RESET_DATA[XLEN-1:0] : sel;
`ifdef REG_BANK_BYPASS_EN
    // wr_qual_i already excludes CLEAR, entry 0 under ZERO_REG and out-of-range targets.
    if (wr_qual_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
`endif
  end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: storage, post-reset clear sweep and write qualification.
// Optional same-cycle write-to-read bypass is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_bank_param_if.slave        bus,
  output state_t                 state_o
);

  localparam int AW = clog2(NREGS);

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_d;
  logic            ready_q;
  logic            wr_qual;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NRP*XLEN-1:0] rs_data;

  assign cnt_d = cnt_q + AW'(1);

  assign wr_qual = (state_q == ST_READY) && bus.wr_en_i &&
                   (32'(bus.rd_addr_i) < NREGS) &&
                   !((ZERO_REG != 0) && (bus.rd_addr_i == '0));

  // Sweep FSM: the counter holds at NREGS-1 once READY, it is not used again until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == AW'(NREGS - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset directly; the sweep zeroes it and reads are masked until it finishes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        regs_q[cnt_q] <= RESET_DATA[XLEN-1:0];
      end else if (wr_qual) begin
        regs_q[bus.rd_addr_i] <= bus.data_i;
      end
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rp
    reg_bank_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
    ) u_rp (
      .state_i   (state_q),
      .addr_i    (bus.rs_addr_i[k*AW +: AW]),
      .regs_i    (regs_q),
`ifdef REG_BANK_BYPASS_EN
      .wr_qual_i (wr_qual),
      .wr_addr_i (bus.rd_addr_i),
      .wr_data_i (bus.data_i),
`endif
      .data_o    (rs_data[k*XLEN +: XLEN])
    );
  end

  assign bus.rs_data_o = rs_data;
  assign bus.ready_o   = ready_q;
  assign state_o       = state_q;

endmodule
